reu_dram_sched: RTL and testbench



---
 rtl/reu_dram_pkg.sv | 29 ++
 rtl/reu_dram_sched_if.sv | 27 ++
 rtl/reu_refresh_timer.sv | 31 +++
 rtl/reu_dram_sched.sv | 144 ++++++++++++++
 tb/tb_reu_dram_sched.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reu_dram_pkg.sv
// rtl/reu_dram_pkg.sv - shared types and constants for the REU DRAM scheduler
package reu_dram_pkg;
  localparam int ROW_W = 10;
  localparam int COL_W = 9;
  localparam int ADDR_W = ROW_W + COL_W;
  localparam int DEF_REFRESH_INTERVAL = 62;
  localparam int DEF_OWED_MAX = 7;

  typedef enum logic [2:0] {IDLE, ROW, COL, COL2, PRE, REF1, REF2, REF3} state_t;

  // {nRAS, nCAS} driven while in each state; refresh is CAS-before-RAS
  localparam logic [1:0] STB_IDLE = 2'b11;
  localparam logic [1:0] STB_ROW  = 2'b01;
  localparam logic [1:0] STB_COL  = 2'b00;
  localparam logic [1:0] STB_REF1 = 2'b10;
  localparam logic [1:0] STB_REF2 = 2'b00;
  localparam logic [1:0] STB_REF3 = 2'b01;

  function automatic logic [1:0] strobeFor(input state_t s);
    case (s)
      ROW:       strobeFor = STB_ROW;
      COL, COL2: strobeFor = STB_COL;
      REF1:      strobeFor = STB_REF1;
      REF2:      strobeFor = STB_REF2;
      REF3:      strobeFor = STB_REF3;
      default:   strobeFor = STB_IDLE;
    endcase
  endfunction
endpackage

// File: rtl/reu_dram_sched_if.sv
// rtl/reu_dram_sched_if.sv - requester-side bus (DMA port, window port, read data)
interface reu_dram_sched_if;
  import reu_dram_pkg::*;

  logic              DMAReq;
  logic              DMAWE;
  logic [ADDR_W-1:0] DMAAddr;
  logic [7:0]        DMAWData;
  logic              DMAAck;
  logic              WinReq;
  logic              WinWE;
  logic [ADDR_W-1:0] WinAddr;
  logic [7:0]        WinWData;
  logic              WinAck;
  logic [7:0]        RData;
  logic              Busy;

  modport master (
    output DMAReq, DMAWE, DMAAddr, DMAWData, WinReq, WinWE, WinAddr, WinWData,
    input  DMAAck, WinAck, RData, Busy
  );

  modport slave (
    input  DMAReq, DMAWE, DMAAddr, DMAWData, WinReq, WinWE, WinAddr, WinWData,
    output DMAAck, WinAck, RData, Busy
  );
endinterface

// File: rtl/reu_refresh_timer.sv
// rtl/reu_refresh_timer.sv - refresh interval counter and saturating owed-refresh count
module reu_refresh_timer import reu_dram_pkg::*; #(
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int OWED_MAX = DEF_OWED_MAX,
  localparam int CW = $clog2(REFRESH_INTERVAL),
  localparam int OW = $clog2(OWED_MAX + 1)
) (
  input  logic          C8M,
  input  logic          RESET,
  input  logic          RefDone,
  output logic [OW-1:0] RefOwed
);
  logic [CW-1:0] intervalCnt;
  logic          wrap;

  assign wrap = (intervalCnt == CW'(REFRESH_INTERVAL - 1));

  always_ff @(posedge C8M) begin
    if (RESET) begin
      intervalCnt <= '0;
      RefOwed     <= '0;
    end else begin
      intervalCnt <= wrap ? '0 : intervalCnt + 1'b1;
      // a tick and a completed refresh in the same cycle cancel out
      if (wrap && !RefDone && RefOwed != OW'(OWED_MAX))
        RefOwed <= RefOwed + 1'b1;
      else if (RefDone && !wrap && RefOwed != '0)
        RefOwed <= RefOwed - 1'b1;
    end
  end
endmodule

// File: rtl/reu_dram_sched.sv
// rtl/reu_dram_sched.sv - DRAM bus scheduler: refresh > DMA > window, registered DRAM pins
// Window port is active only when REU_WINDOW_EN is defined.
module reu_dram_sched import reu_dram_pkg::*; #(
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int OWED_MAX = DEF_OWED_MAX
) (
  input  logic              C8M,
  input  logic              RESET,
  reu_dram_sched_if.slave   reqBus,
  output logic              nRAS,
  output logic              nCAS,
  output logic              nRWE,
  output logic [ROW_W-1:0]  RA,
  output logic [7:0]        RDOut,
  output logic              RDOE,
  input  logic [7:0]        RDIn
);
  localparam int OW = $clog2(OWED_MAX + 1);

  state_t            state, stateNext;
  logic [OW-1:0]     refOwed;
  logic              refDone;
  logic              winReqEn;
  logic              isRef, isRefNext, isWin, isWinNext, we, weNext;
  logic [ADDR_W-1:0] addr, addrNext;
  logic [7:0]        wdata, wdataNext;
  logic              nRASNext, nCASNext, nRWENext, RDOENext, dmaAckNext, winAckNext;
  logic [ROW_W-1:0]  RANext;
  logic [7:0]        RDOutNext;
  logic              colNext;

`ifdef REU_WINDOW_EN
  assign winReqEn = reqBus.WinReq;
`else
  logic unusedWinReq;
  assign unusedWinReq = reqBus.WinReq;
  assign winReqEn = 1'b0;
`endif

  assign refDone = (state == PRE) && isRef;

  reu_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL),
    .OWED_MAX(OWED_MAX)
  ) uTimer (
    .C8M(C8M),
    .RESET(RESET),
    .RefDone(refDone),
    .RefOwed(refOwed)
  );

  always_comb begin
    stateNext = state;
    isRefNext = isRef;
    isWinNext = isWin;
    weNext    = we;
    addrNext  = addr;
    wdataNext = wdata;
    case (state)
      IDLE: begin
        if (refOwed != '0) begin
          stateNext = REF1;
          isRefNext = 1'b1;
        end else if (reqBus.DMAReq) begin
          stateNext = ROW;
          isRefNext = 1'b0;
          isWinNext = 1'b0;
          weNext    = reqBus.DMAWE;
          addrNext  = reqBus.DMAAddr;
          wdataNext = reqBus.DMAWData;
        end else if (winReqEn) begin
          stateNext = ROW;
          isRefNext = 1'b0;
          isWinNext = 1'b1;
          weNext    = reqBus.WinWE;
          addrNext  = reqBus.WinAddr;
          wdataNext = reqBus.WinWData;
        end
      end
      ROW:     stateNext = COL;
      COL:     stateNext = COL2;
      COL2:    stateNext = PRE;
      REF1:    stateNext = REF2;
      REF2:    stateNext = REF3;
      REF3:    stateNext = PRE;
      default: stateNext = IDLE;
    endcase

    // pin values are computed for the state being entered so they are registered with it
    colNext               = (stateNext == COL) || (stateNext == COL2);
    {nRASNext, nCASNext}  = strobeFor(stateNext);
    nRWENext              = !(colNext && weNext);
    RDOENext              = colNext && weNext;
    RANext                = RA;
    RDOutNext             = RDOut;
    if (stateNext == ROW)
      RANext = addrNext[ADDR_W-1:COL_W];
    if (colNext) begin
      RANext    = {{(ROW_W-COL_W){1'b0}}, addrNext[COL_W-1:0]};
      RDOutNext = wdataNext;
    end
    dmaAckNext = (stateNext == PRE) && !isRefNext && !isWinNext;
    winAckNext = (stateNext == PRE) && !isRefNext && isWinNext;
  end

  always_ff @(posedge C8M) begin
    if (RESET) begin
      state          <= IDLE;
      isRef          <= 1'b0;
      isWin          <= 1'b0;
      we             <= 1'b0;
      addr           <= '0;
      wdata          <= '0;
      nRAS           <= 1'b1;
      nCAS           <= 1'b1;
      nRWE           <= 1'b1;
      RA             <= '0;
      RDOut          <= '0;
      RDOE           <= 1'b0;
      reqBus.DMAAck  <= 1'b0;
      reqBus.WinAck  <= 1'b0;
      reqBus.RData   <= '0;
      reqBus.Busy    <= 1'b0;
    end else begin
      state          <= stateNext;
      isRef          <= isRefNext;
      isWin          <= isWinNext;
      we             <= weNext;
      addr           <= addrNext;
      wdata          <= wdataNext;
      nRAS           <= nRASNext;
      nCAS           <= nCASNext;
      nRWE           <= nRWENext;
      RA             <= RANext;
      RDOut          <= RDOutNext;
      RDOE           <= RDOENext;
      reqBus.DMAAck  <= dmaAckNext;
      reqBus.WinAck  <= winAckNext;
      reqBus.Busy    <= (stateNext != IDLE);
      if (state == COL2 && !we)
        reqBus.RData <= RDIn;
    end
  end
endmodule

// File: tb/tb_reu_dram_sched.sv
// tb/tb_reu_dram_sched.sv - self-checking bench for reu_dram_sched
// Exercises the window port only when REU_WINDOW_EN is defined.
module tb_reu_dram_sched;
  typedef struct {
    logic       win;
    logic       we;
    logic [18:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdin;
    logic [9:0] expRow;
    logic [9:0] expCol;
    logic [7:0] expRData;
  } vec_t;

  logic       C8M = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] RDIn = 8'h00;
  logic       nRAS, nCAS, nRWE, RDOE;
  logic [9:0] RA;
  logic [7:0] RDOut;
  logic       nRAS2, nCAS2, unusedRwe2, unusedOe2;
  logic [9:0] unusedRa2;
  logic [7:0] unusedRdOut2;

  reu_dram_sched_if bus();
  reu_dram_sched_if bus2();

  reu_dram_sched dut (
    .C8M(C8M), .RESET(RESET), .reqBus(bus),
    .nRAS(nRAS), .nCAS(nCAS), .nRWE(nRWE), .RA(RA),
    .RDOut(RDOut), .RDOE(RDOE), .RDIn(RDIn)
  );

  // fast-ticking instance so the owed counter can be driven into saturation
  reu_dram_sched #(.REFRESH_INTERVAL(3), .OWED_MAX(7)) dut2 (
    .C8M(C8M), .RESET(RESET), .reqBus(bus2),
    .nRAS(nRAS2), .nCAS(nCAS2), .nRWE(unusedRwe2), .RA(unusedRa2),
    .RDOut(unusedRdOut2), .RDOE(unusedOe2), .RDIn(8'h00)
  );

  always #5 C8M = ~C8M;

  int   total = 0, bad = 0, cyc = 0;
  vec_t sb[$];
  vec_t monRec;
  bit   sawRow = 0, holdMode = 0, prevRAS = 1, prevCAS = 1;
  int   phase = 0, refPhase = 0, rowCycle = 0, lastRef = -1, refCount = 0;
  int   dmaAckCount = 0, winAckCount = 0, lastDmaAck = 0, lastWinAck = 0, maxOwed = 0;
  int   eCnt = 0, eOwed = 0, maxOwed2 = 0;
  bit   done2, wrap2, drainSeen = 0, pRAS2 = 1, pCAS2 = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic vec_t mk(input logic win, input logic we, input logic [18:0] addr,
                              input logic [7:0] wdata, input logic [7:0] rdin,
                              input logic [9:0] r, input logic [9:0] c, input logic [7:0] rd);
    vec_t v;
    v.win = win; v.we = we; v.addr = addr; v.wdata = wdata; v.rdin = rdin;
    v.expRow = r; v.expCol = c; v.expRData = rd;
    return v;
  endfunction

  always @(posedge C8M) cyc++;

  // pin monitor for the main instance
  always @(negedge C8M) begin
    if (RESET) begin
      phase = 0; refPhase = 0; prevRAS = 1; prevCAS = 1;
    end else begin
      if (!nRAS && nCAS && prevRAS && prevCAS) begin
        rowCycle = cyc; phase = 1; sawRow = 1;
        if (!holdMode) begin
          if (sb.size() == 0) failNow("unexpected ROW");
          else chk("row RA", RA, sb[0].expRow);
        end
      end else if (!nRAS && !nCAS && (phase == 1 || phase == 2)) begin
        phase++;
        if (!holdMode && sb.size() != 0) begin
          chk("col RA", RA, sb[0].expCol);
          chk("col nRWE", nRWE, !sb[0].we);
          chk("col RDOE", RDOE, sb[0].we);
          if (sb[0].we) chk("col RDOut", RDOut, sb[0].wdata);
        end
      end
      if (!nRWE && !(phase == 2 || phase == 3)) failNow("nRWE low outside COL");
      if (nRAS && !nCAS) begin
        refPhase = 1; refCount++;
        if (holdMode && lastRef >= 0) chk("refresh spacing <=71", (cyc - lastRef) <= 71, 1);
        lastRef = cyc;
      end else if (refPhase == 1) begin
        chk("cbr REF2", {nRAS, nCAS}, 2'b00); refPhase = 2;
      end else if (refPhase == 2) begin
        chk("cbr REF3", {nRAS, nCAS}, 2'b01); refPhase = 3;
      end else if (refPhase == 3) begin
        chk("cbr PRE", {nRAS, nCAS, nRWE}, 3'b111); refPhase = 0;
      end
      if (holdMode && int'(dut.refOwed) > maxOwed) maxOwed = int'(dut.refOwed);
      if (bus.DMAAck || bus.WinAck) begin
        chk("ack strobes", {nRAS, nCAS, nRWE, RDOE}, 4'b1110);
        chk("ack latency", cyc - rowCycle, 3);
        chk("ack Busy", bus.Busy, 1);
        if (!holdMode) begin
          if (sb.size() == 0) failNow("unexpected ack");
          else begin
            monRec = sb.pop_front();
            chk("ack port", bus.WinAck, monRec.win);
            chk("RData", bus.RData, monRec.expRData);
          end
        end
        if (bus.DMAAck) begin dmaAckCount++; lastDmaAck = cyc; end
        if (bus.WinAck) begin winAckCount++; lastWinAck = cyc; end
        phase = 0;
      end
      prevRAS = nRAS; prevCAS = nCAS;
    end
  end

  // reference model of the owed counter in the fast-ticking instance
  always @(negedge C8M) begin
    if (!RESET) begin
      chk("owed model", 32'(dut2.refOwed), eOwed);
      if (int'(dut2.refOwed) > maxOwed2) maxOwed2 = int'(dut2.refOwed);
    end
    done2 = nRAS2 && nCAS2 && !pRAS2 && pCAS2;
    if (RESET) begin
      eCnt = 0; eOwed = 0; pRAS2 = 1; pCAS2 = 1;
    end else begin
      wrap2 = (eCnt == 2);
      eCnt = wrap2 ? 0 : eCnt + 1;
      if (wrap2 && !done2 && eOwed < 7) eOwed++;
      else if (done2 && !wrap2 && eOwed > 0) begin
        if (eOwed == 7) drainSeen = 1;
        eOwed--;
      end
      pRAS2 = nRAS2; pCAS2 = nCAS2;
    end
  end

  task automatic doReset();
    @(posedge C8M); #1;
    RESET = 1;
    repeat (3) @(posedge C8M);
    #1 RESET = 0;
  endtask

  task automatic doAccess(input vec_t v);
    bit got, scr;
    @(posedge C8M); #1;
    sb.push_back(v);
    RDIn = v.rdin; sawRow = 0; got = 0; scr = 0;
    if (v.win) begin
      bus.WinWE = v.we; bus.WinAddr = v.addr; bus.WinWData = v.wdata; bus.WinReq = 1;
    end else begin
      bus.DMAWE = v.we; bus.DMAAddr = v.addr; bus.DMAWData = v.wdata; bus.DMAReq = 1;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge C8M); #1;
      if (sawRow && !scr) begin
        // request inputs change after grant; the access must use the latched values
        scr = 1;
        if (v.win) begin bus.WinAddr = ~v.addr; bus.WinWData = ~v.wdata; bus.WinWE = ~v.we; end
        else begin bus.DMAAddr = ~v.addr; bus.DMAWData = ~v.wdata; bus.DMAWE = ~v.we; end
      end
      got = v.win ? bus.WinAck : bus.DMAAck;
    end
    if (!got) begin failNow("ack timeout"); sb.delete(); end
    @(posedge C8M); #1;
    bus.DMAReq = 0; bus.WinReq = 0;
  endtask

  vec_t tbl[8];
  int   n0;
  bit   got;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    {bus.DMAReq, bus.DMAWE, bus.WinReq, bus.WinWE} = 4'b0;
    bus.DMAAddr = '0; bus.DMAWData = '0; bus.WinAddr = '0; bus.WinWData = '0;
    {bus2.DMAReq, bus2.DMAWE, bus2.WinReq, bus2.WinWE} = 4'b0;
    bus2.DMAAddr = '0; bus2.DMAWData = '0; bus2.WinAddr = '0; bus2.WinWData = '0;

    tbl[0] = mk(0, 1, 19'h12345, 8'h5A, 8'h00, 10'h091, 10'h145, 8'h00);
    tbl[1] = mk(0, 0, 19'h12345, 8'h00, 8'h5A, 10'h091, 10'h145, 8'h5A);
    tbl[2] = mk(0, 1, 19'h00000, 8'hFF, 8'h00, 10'h000, 10'h000, 8'h5A);
    tbl[3] = mk(0, 1, 19'h7FFFF, 8'h00, 8'hEE, 10'h3FF, 10'h1FF, 8'h5A);
    tbl[4] = mk(0, 0, 19'h7FFFF, 8'h11, 8'hA5, 10'h3FF, 10'h1FF, 8'hA5);
    tbl[5] = mk(0, 0, 19'h00200, 8'h22, 8'h3C, 10'h001, 10'h000, 8'h3C);
    tbl[6] = mk(0, 1, 19'h401FF, 8'hC3, 8'h00, 10'h200, 10'h1FF, 8'h3C);
    tbl[7] = mk(0, 0, 19'h3FE00, 8'h44, 8'h81, 10'h1FF, 10'h000, 8'h81);

    doReset();
    @(negedge C8M); #1;
    chk("reset strobes", {nRAS, nCAS, nRWE, RDOE}, 4'b1110);
    chk("reset RA", RA, 0);
    chk("reset RDOut", RDOut, 0);
    chk("reset acks", {bus.DMAAck, bus.WinAck}, 2'b00);
    chk("reset RData", bus.RData, 0);
    chk("reset Busy", bus.Busy, 0);
    chk("reset owed", 32'(dut.refOwed), 0);

    for (int i = 0; i < 8; i++) doAccess(tbl[i]);

    // simultaneous DMA and window requests
    doReset();
    sb.push_back(mk(0, 0, 19'h00400, 8'h00, 8'h77, 10'h002, 10'h000, 8'h77));
`ifdef REU_WINDOW_EN
    sb.push_back(mk(1, 1, 19'h0F0F0, 8'h69, 8'h00, 10'h078, 10'h0F0, 8'h77));
`endif
    n0 = winAckCount;
    @(posedge C8M); #1;
    RDIn = 8'h77;
    bus.DMAWE = 0; bus.DMAAddr = 19'h00400; bus.DMAReq = 1;
    bus.WinWE = 1; bus.WinAddr = 19'h0F0F0; bus.WinWData = 8'h69; bus.WinReq = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge C8M); #1; got = bus.DMAAck; end
    chk("dual DMA ack first", got, 1);
    @(posedge C8M); #1;
    bus.DMAReq = 0;
`ifdef REU_WINDOW_EN
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge C8M); #1; got = bus.WinAck; end
    chk("dual Win ack", got, 1);
    chk("WinAck after DMAAck", lastWinAck - lastDmaAck, 5);
    @(posedge C8M); #1;
    bus.WinReq = 0;
`else
    repeat (15) @(negedge C8M);
    #1 chk("WinAck disabled", winAckCount - n0, 0);
    bus.WinReq = 0;
`endif
    if (sb.size() != 0) begin failNow("dual scoreboard leftover"); sb.delete(); end

    // continuous DMA: refresh must still be scheduled
    doReset();
    holdMode = 1; lastRef = -1; maxOwed = 0; n0 = refCount;
    bus.DMAWE = 0; bus.DMAAddr = 19'h00000; bus.DMAReq = 1;
    repeat (200) @(posedge C8M);
    #1 bus.DMAReq = 0;
    repeat (10) @(posedge C8M);
    #1 holdMode = 0;
    chk("hold refreshes >=3", (refCount - n0) >= 3, 1);
    chk("hold owed <=1", maxOwed <= 1, 1);

    // reset during COL of a write
    doReset();
    sb.push_back(mk(0, 1, 19'h12345, 8'h5A, 8'h00, 10'h091, 10'h145, 8'h00));
    sawRow = 0; got = 0;
    bus.DMAWE = 1; bus.DMAAddr = 19'h12345; bus.DMAWData = 8'h5A; bus.DMAReq = 1;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge C8M); #1; got = sawRow; end
    chk("midreset ROW seen", got, 1);
    @(posedge C8M); #1;
    RESET = 1; bus.DMAReq = 0; sb.delete();
    n0 = dmaAckCount;
    @(posedge C8M);
    @(negedge C8M); #1;
    chk("midreset strobes", {nRAS, nCAS, nRWE, RDOE}, 4'b1110);
    chk("midreset DMAAck", bus.DMAAck, 0);
    chk("midreset Busy", bus.Busy, 0);
    @(posedge C8M); #1;
    RESET = 0;
    repeat (10) @(posedge C8M);
    #1 chk("midreset no ack", dmaAckCount - n0, 0);
    doAccess(mk(0, 0, 19'h12345, 8'h00, 8'h5A, 10'h091, 10'h145, 8'h5A));

    chk("owed saturated at 7", maxOwed2, 7);
    chk("owed drained from 7", drainSeen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
